seven_segment_scanner: RTL and testbench

//  Time-multiplexed driver for a common-anode 7-segment display bank.

---
 rtl/seven_segment_scanner_pkg.sv | 30 +++
 rtl/seven_segment_scanner_if.sv | 25 ++
 rtl/hex_to_seven_segment.sv | 34 +++
 rtl/seven_segment_scanner.sv | 165 ++++++++++++++++
 tb/tb_seven_segment_scanner.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/seven_segment_scanner_pkg.sv
// Shared definitions for the seven-segment scanner: glyphs and scan states.
// Glyphs are active-low, bit order {g,f,e,d,c,b,a}.
package seven_segment_scanner_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // IDLE: dark and waiting for Enable; BLANK: anti-ghosting gap; SHOW: one digit lit.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } scanState_t;

endpackage

// File: rtl/seven_segment_scanner_if.sv
// Display-side bundle of the scanner: scan controls and frame data in,
// active-low display drive out. The scanner is the slave side.
interface seven_segment_scanner_if #(
    parameter int DIGITS = 4
);
    logic                  ScanTick;
    logic                  Enable;
    logic                  LeadingZeroBlank;
    logic [4*DIGITS-1:0]   Value;
    logic [DIGITS-1:0]     DotMask;
    logic [DIGITS-1:0]     Anodes;
    logic [6:0]            Segments;
    logic                  Dot;
    logic                  FrameStart;

    modport master (
        output ScanTick, Enable, LeadingZeroBlank, Value, DotMask,
        input  Anodes, Segments, Dot, FrameStart
    );

    modport slave (
        input  ScanTick, Enable, LeadingZeroBlank, Value, DotMask,
        output Anodes, Segments, Dot, FrameStart
    );
endinterface

// File: rtl/hex_to_seven_segment.sv
// Combinational hex nibble to active-low seven-segment glyph (b and d lower-case).
module hex_to_seven_segment
    import seven_segment_scanner_pkg::*;
(
    input  logic [3:0] Nibble,
    output logic [6:0] Segments
);

    // Glyph lookup; every nibble value has an entry.
    always_comb begin
        // NOTE: a default ahead of the case keeps every path assigned, so no latch is inferred.
        Segments = SEG_BLANK;
        case (Nibble)
            4'h0: Segments = SEG_0;
            4'h1: Segments = SEG_1;
            4'h2: Segments = SEG_2;
            4'h3: Segments = SEG_3;
            4'h4: Segments = SEG_4;
            4'h5: Segments = SEG_5;
            4'h6: Segments = SEG_6;
            4'h7: Segments = SEG_7;
            4'h8: Segments = SEG_8;
            4'h9: Segments = SEG_9;
            4'hA: Segments = SEG_A;
            4'hB: Segments = SEG_B;
            4'hC: Segments = SEG_C;
            4'hD: Segments = SEG_D;
            4'hE: Segments = SEG_E;
            4'hF: Segments = SEG_F;
            default: Segments = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed common-anode display driver. Scan timing advances only on
// ScanTick strobes; a coherent copy of Value/DotMask/LeadingZeroBlank is taken
// once per frame so mid-frame input changes never tear the display.
module seven_segment_scanner
    import seven_segment_scanner_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int ON_TICKS    = 4,
    parameter int BLANK_TICKS = 1,
    parameter int TICK_BITS   = 4
)
(
    input logic                    InputCLK,
    input logic                    Reset,
    seven_segment_scanner_if.slave Bus
);

    localparam int IDX_BITS = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_BITS-1:0]  LAST_DIGIT = IDX_BITS'(DIGITS - 1);
    localparam logic [TICK_BITS-1:0] ON_LAST    = TICK_BITS'(ON_TICKS - 1);
    localparam logic [TICK_BITS-1:0] BLANK_LAST = TICK_BITS'((BLANK_TICKS > 0) ? BLANK_TICKS - 1 : 0);
    // Every digit is entered through the gap, unless the gap is configured away.
    localparam scanState_t DIGIT_ENTRY = (BLANK_TICKS > 0) ? ST_BLANK : ST_SHOW;

    scanState_t           stateReg, stateNext;
    logic [IDX_BITS-1:0]  digitIdx, digitIdxNext;
    logic [TICK_BITS-1:0] tickCount, tickCountNext;
    logic                 frameLatch;

    logic [4*DIGITS-1:0]  frameValue;
    logic [DIGITS-1:0]    frameDots;
    logic                 frameLzb;
    logic [DIGITS-1:0]    blankMask;
    logic                 zeroRun;

    logic [3:0]           shownNibble;
    logic [6:0]           glyph;

    logic [DIGITS-1:0]    anodesReg;
    logic [6:0]           segmentsReg;
    logic                 dotReg;
    logic                 frameStartReg;

    // Scan sequencing: next state, digit index, tick count and frame-latch strobe.
    always_comb begin
        stateNext     = stateReg;
        digitIdxNext  = digitIdx;
        tickCountNext = tickCount;
        frameLatch    = 1'b0;
        if (!Bus.Enable) begin
            stateNext     = ST_IDLE;
            digitIdxNext  = '0;
            tickCountNext = '0;
        end else begin
            case (stateReg)
                ST_IDLE: begin
                    // A ScanTick in this cycle is deliberately not counted.
                    stateNext     = DIGIT_ENTRY;
                    digitIdxNext  = '0;
                    tickCountNext = '0;
                    frameLatch    = 1'b1;
                end
                ST_BLANK: begin
                    if (Bus.ScanTick) begin
                        if (tickCount == BLANK_LAST) begin
                            stateNext     = ST_SHOW;
                            tickCountNext = '0;
                        end else begin
                            tickCountNext = tickCount + 1'b1;
                        end
                    end
                end
                ST_SHOW: begin
                    if (Bus.ScanTick) begin
                        if (tickCount == ON_LAST) begin
                            stateNext     = DIGIT_ENTRY;
                            tickCountNext = '0;
                            if (digitIdx == LAST_DIGIT) begin
                                digitIdxNext = '0;
                                frameLatch   = 1'b1;
                            end else begin
                                digitIdxNext = digitIdx + 1'b1;
                            end
                        end else begin
                            tickCountNext = tickCount + 1'b1;
                        end
                    end
                end
                default: stateNext = ST_IDLE;
            endcase
        end
    end

    // Scan state registers.
    always_ff @(posedge InputCLK or posedge Reset) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of block order.
        if (Reset) begin
            stateReg  <= ST_IDLE;
            digitIdx  <= '0;
            tickCount <= '0;
        end else begin
            stateReg  <= stateNext;
            digitIdx  <= digitIdxNext;
            tickCount <= tickCountNext;
        end
    end

    // Frame snapshot, taken on entry from IDLE and on every digit wrap.
    always_ff @(posedge InputCLK or posedge Reset) begin
        // NOTE: the snapshot is plain flops rather than a memory, so it takes the async clear like everything else.
        if (Reset) begin
            frameValue <= '0;
            frameDots  <= '0;
            frameLzb   <= 1'b0;
        end else if (frameLatch) begin
            frameValue <= Bus.Value;
            frameDots  <= Bus.DotMask;
            frameLzb   <= Bus.LeadingZeroBlank;
        end
    end

    // Leading-zero mask: zero digits from the top down to the first nonzero; digit 0 always shows.
    always_comb begin
        blankMask = '0;
        zeroRun   = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zeroRun      = zeroRun & (frameValue[4*i +: 4] == 4'h0);
            blankMask[i] = frameLzb & zeroRun;
        end
    end

    assign shownNibble = frameValue[4*digitIdx +: 4];

    hex_to_seven_segment uDecode (
        .Nibble   (shownNibble),
        .Segments (glyph)
    );

    // Registered display drive, one cycle behind the scan state.
    always_ff @(posedge InputCLK or posedge Reset) begin
        if (Reset) begin
            anodesReg     <= '1;
            segmentsReg   <= SEG_BLANK;
            dotReg        <= 1'b1;
            frameStartReg <= 1'b0;
        end else begin
            frameStartReg <= frameLatch;
            if (stateReg == ST_SHOW) begin
                anodesReg   <= ~(DIGITS'(1) << digitIdx);
                segmentsReg <= blankMask[digitIdx] ? SEG_BLANK : glyph;
                dotReg      <= ~frameDots[digitIdx];
            end else begin
                anodesReg   <= '1;
                segmentsReg <= SEG_BLANK;
                dotReg      <= 1'b1;
            end
        end
    end

    assign Bus.Anodes     = anodesReg;
    assign Bus.Segments   = segmentsReg;
    assign Bus.Dot        = dotReg;
    assign Bus.FrameStart = frameStartReg;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Self-checking bench: a gapped build (BLANK_TICKS=1) and a gapless build
// (BLANK_TICKS=0) share one stimulus; frames are compared against a timing
// model with ScanTick on every third cycle.
module tb_seven_segment_scanner;

    localparam int DIGITS = 4;

    logic InputCLK = 1'b0;
    logic Reset;

    logic        scanTick;
    logic        enable;
    logic        lzb;
    logic [15:0] value;
    logic [3:0]  dotMask;

    int checks = 0;
    int errors = 0;

    seven_segment_scanner_if #(.DIGITS(DIGITS)) bus  ();
    seven_segment_scanner_if #(.DIGITS(DIGITS)) bus0 ();

    assign bus.ScanTick          = scanTick;
    assign bus.Enable            = enable;
    assign bus.LeadingZeroBlank  = lzb;
    assign bus.Value             = value;
    assign bus.DotMask           = dotMask;
    assign bus0.ScanTick         = scanTick;
    assign bus0.Enable           = enable;
    assign bus0.LeadingZeroBlank = lzb;
    assign bus0.Value            = value;
    assign bus0.DotMask          = dotMask;

    seven_segment_scanner #(.DIGITS(DIGITS), .ON_TICKS(4), .BLANK_TICKS(1), .TICK_BITS(4)) dut (
        .InputCLK (InputCLK),
        .Reset    (Reset),
        .Bus      (bus)
    );

    seven_segment_scanner #(.DIGITS(DIGITS), .ON_TICKS(4), .BLANK_TICKS(0), .TICK_BITS(4)) dut0 (
        .InputCLK (InputCLK),
        .Reset    (Reset),
        .Bus      (bus0)
    );

    always #5 InputCLK = ~InputCLK;

    // Vector record: inputs plus expected glyph per digit {d3,d2,d1,d0} and active-low dot per digit.
    typedef struct {
        logic [15:0]     val;
        logic [3:0]      dots;
        logic            lz;
        logic [3:0][6:0] seg;
        logic [3:0]      dotOut;
    } vec_t;

    vec_t vecs [9];

    // Per-cycle capture of both builds.
    logic [3:0] capAn  [256];
    logic [6:0] capSeg [256];
    logic       capDot [256];
    logic       capFs  [256];
    logic [3:0] capAn0 [256];
    logic [6:0] capSeg0[256];
    logic       capDot0[256];
    logic       capFs0 [256];
    int         nCap;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic stepCycle(input logic tick);
        scanTick = tick;
        @(posedge InputCLK);
        #1;
    endtask

    task automatic capture(input int n);
        for (int k = 0; k < n; k++) begin
            stepCycle(nCap % 3 == 2);
            capAn[nCap]   = bus.Anodes;
            capSeg[nCap]  = bus.Segments;
            capDot[nCap]  = bus.Dot;
            capFs[nCap]   = bus.FrameStart;
            capAn0[nCap]  = bus0.Anodes;
            capSeg0[nCap] = bus0.Segments;
            capDot0[nCap] = bus0.Dot;
            capFs0[nCap]  = bus0.FrameStart;
            nCap++;
        end
    endtask

    task automatic goIdle();
        enable = 1'b0;
        stepCycle(1'b0);
        stepCycle(1'b0);
    endtask

    // Gapped build: 3-sample gap then 12 lit samples per digit; frame latched at samples 0 and 59.
    // Gapless build: dark at sample 0 only, 12 lit samples per digit (first digit 11); wrap at 47.
    task automatic checkFrame(input string tag, input int n,
                              input logic [3:0][6:0] segOld, input logic [3:0] dotOld,
                              input logic [3:0][6:0] segNew, input logic [3:0] dotNew);
        for (int s = 0; s < n; s++) begin
            int pos, dig, dig0;
            logic [3:0]      expAn, expAn0;
            logic [6:0]      expSeg, expSeg0;
            logic            expDot, expDot0, expFs, expFs0;
            logic [3:0][6:0] segTab, segTab0;
            logic [3:0]      dotTab, dotTab0;
            pos     = s % 15;
            dig     = (s / 15) % 4;
            dig0    = (s / 12) % 4;
            segTab  = (s >= 60) ? segNew : segOld;
            dotTab  = (s >= 60) ? dotNew : dotOld;
            segTab0 = (s >= 48) ? segNew : segOld;
            dotTab0 = (s >= 48) ? dotNew : dotOld;
            expAn   = (pos < 3) ? 4'hF : ~(4'b0001 << dig);
            expSeg  = (pos < 3) ? 7'h7F : segTab[dig];
            expDot  = (pos < 3) ? 1'b1 : dotTab[dig];
            expFs   = (s == 0) || (s == 59) || (s == 119);
            expAn0  = (s == 0) ? 4'hF : ~(4'b0001 << dig0);
            expSeg0 = (s == 0) ? 7'h7F : segTab0[dig0];
            expDot0 = (s == 0) ? 1'b1 : dotTab0[dig0];
            expFs0  = (s == 0) || (s == 47) || (s == 95);
            check($sformatf("%s s%0d anodes", tag, s),    32'(capAn[s]),   32'(expAn));
            check($sformatf("%s s%0d segments", tag, s),  32'(capSeg[s]),  32'(expSeg));
            check($sformatf("%s s%0d dot", tag, s),       32'(capDot[s]),  32'(expDot));
            check($sformatf("%s s%0d framestart", tag, s), 32'(capFs[s]),  32'(expFs));
            check($sformatf("%s s%0d nogap anodes", tag, s),   32'(capAn0[s]),  32'(expAn0));
            check($sformatf("%s s%0d nogap segments", tag, s), 32'(capSeg0[s]), 32'(expSeg0));
            check($sformatf("%s s%0d nogap dot", tag, s),      32'(capDot0[s]), 32'(expDot0));
            check($sformatf("%s s%0d nogap framestart", tag, s), 32'(capFs0[s]), 32'(expFs0));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic found;
        logic [3:0] firstLit;

        vecs[0] = '{16'h1234, 4'b0000, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111};
        vecs[1] = '{16'h0050, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'b1111};
        vecs[2] = '{16'h0000, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111};
        vecs[3] = '{16'h0050, 4'b0100, 1'b1, {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'b1011};
        vecs[4] = '{16'hABCD, 4'b1001, 1'b0, {7'h08, 7'h03, 7'h46, 7'h21}, 4'b0110};
        vecs[5] = '{16'h0050, 4'b0000, 1'b0, {7'h40, 7'h40, 7'h12, 7'h40}, 4'b1111};
        vecs[6] = '{16'h0F0E, 4'b0000, 1'b1, {7'h7F, 7'h0E, 7'h40, 7'h06}, 4'b1111};
        vecs[7] = '{16'h0007, 4'b1111, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h78}, 4'b0000};
        vecs[8] = '{16'h5689, 4'b0000, 1'b1, {7'h12, 7'h02, 7'h00, 7'h10}, 4'b1111};

        Reset    = 1'b1;
        scanTick = 1'b0;
        enable   = 1'b0;
        lzb      = 1'b0;
        value    = 16'h0000;
        dotMask  = 4'b0000;

        // Reset state.
        @(posedge InputCLK);
        @(posedge InputCLK);
        #1;
        check("reset anodes",     32'(bus.Anodes),     32'hF);
        check("reset segments",   32'(bus.Segments),   32'h7F);
        check("reset dot",        32'(bus.Dot),        32'h1);
        check("reset framestart", 32'(bus.FrameStart), 32'h0);
        check("reset nogap anodes", 32'(bus0.Anodes),  32'hF);
        @(negedge InputCLK);
        Reset = 1'b0;
        stepCycle(1'b0);

        // Table-driven frames.
        for (int v = 0; v < 9; v++) begin
            goIdle();
            value   = vecs[v].val;
            dotMask = vecs[v].dots;
            lzb     = vecs[v].lz;
            enable  = 1'b1;
            nCap    = 0;
            capture(64);
            checkFrame($sformatf("v%0d", v), 64, vecs[v].seg, vecs[v].dotOut, vecs[v].seg, vecs[v].dotOut);
        end

        // Mid-frame value change shows only after the next frame latch.
        goIdle();
        value   = 16'h1234;
        dotMask = 4'b0000;
        lzb     = 1'b0;
        enable  = 1'b1;
        nCap    = 0;
        capture(20);
        value   = 16'hABCD;
        dotMask = 4'b1001;
        capture(110);
        checkFrame("tear", 130, vecs[0].seg, vecs[0].dotOut, vecs[4].seg, vecs[4].dotOut);

        // ScanTick coincident with Enable rising is not counted.
        goIdle();
        value   = 16'h1234;
        dotMask = 4'b0000;
        enable  = 1'b1;
        stepCycle(1'b1);
        for (int k = 0; k < 4; k++) stepCycle(1'b0);
        check("tick at enable ignored, still gap", 32'(bus.Anodes), 32'hF);
        stepCycle(1'b1);
        check("gap output lag", 32'(bus.Anodes), 32'hF);
        stepCycle(1'b0);
        check("first digit after one gap tick", 32'(bus.Anodes), 32'hE);
        check("nogap first digit", 32'(bus0.Anodes), 32'hE);
        stepCycle(1'b1);
        stepCycle(1'b1);
        stepCycle(1'b1);
        check("nogap digit0 held for four ticks", 32'(bus0.Anodes), 32'hE);
        stepCycle(1'b0);
        check("nogap digit1 after fourth tick", 32'(bus0.Anodes), 32'hD);

        // Enable falling during digit 2.
        goIdle();
        enable = 1'b1;
        found  = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            stepCycle(k % 3 == 2);
            if (bus.Anodes == 4'b1011) found = 1'b1;
        end
        check("reach digit 2 within budget", 32'(found), 32'h1);
        enable = 1'b0;
        stepCycle(1'b0);
        check("disable output lag", 32'(bus.Anodes), 32'hB);
        stepCycle(1'b0);
        check("disable dark anodes", 32'(bus.Anodes), 32'hF);
        check("disable dark segments", 32'(bus.Segments), 32'h7F);
        stepCycle(1'b0);
        enable = 1'b1;
        stepCycle(1'b0);
        check("re-enable framestart", 32'(bus.FrameStart), 32'h1);
        firstLit = 4'hF;
        for (int k = 0; k < 50 && firstLit == 4'hF; k++) begin
            stepCycle(k % 3 == 2);
            firstLit = bus.Anodes;
        end
        check("re-enable restarts at digit 0", 32'(firstLit), 32'hE);

        // Asynchronous reset mid-SHOW.
        goIdle();
        value   = 16'h1234;
        dotMask = 4'b0001;
        enable  = 1'b1;
        nCap    = 0;
        capture(8);
        check("pre-reset digit0 lit", 32'(bus.Anodes), 32'hE);
        check("pre-reset dot on", 32'(bus.Dot), 32'h0);
        #2;
        Reset = 1'b1;
        #1;
        check("async reset anodes",   32'(bus.Anodes),   32'hF);
        check("async reset segments", 32'(bus.Segments), 32'h7F);
        check("async reset dot",      32'(bus.Dot),      32'h1);
        check("async reset nogap anodes", 32'(bus0.Anodes), 32'hF);
        @(negedge InputCLK);
        Reset = 1'b0;
        stepCycle(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
